// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - opcode/operand fetch FSM feeding the decoder and stepping the PC
// Reads 1-3 instruction bytes at pc, presents them with valid/ready, and releases the PC on handoff.
module instr_fetch #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_flush,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [7:0]            i_mem_rdata,
  output logic                  o_instr_valid,
  input  logic                  i_instr_ready,
  output logic [7:0]            o_instr_opcode,
  output logic [7:0]            o_instr_op1,
  output logic [7:0]            o_instr_op2,
  output logic [1:0]            o_instr_size,
  output logic                  o_instr_illegal,
  output logic                  o_pc_hold
);

  typedef enum logic [2:0] {REQ_OP, CAP_OP, CAP_B1, CAP_B2, VALID} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_TWO = 2;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_opcode;
  logic [7:0]            r_op1;
  logic [7:0]            r_op2;
  logic [1:0]            r_size;
  logic                  r_illegal;
  logic [1:0]            w_dec_size;
  logic                  w_handoff;
  logic [ADDR_WIDTH-1:0] w_pc_p1;
  logic [ADDR_WIDTH-1:0] w_pc_p2;

  assign w_pc_p1 = i_pc + ADDR_ONE;
  assign w_pc_p2 = i_pc + ADDR_TWO;

  always_comb begin
    case (i_mem_rdata[7:6])
      2'b01:   w_dec_size = 2'd2;
      2'b10:   w_dec_size = 2'd3;
      default: w_dec_size = 2'd1;
    endcase
  end

  // Flush and reset both suppress the handoff so the PC never moves on an aborted instruction.
  assign w_handoff = (r_state == VALID) && i_instr_ready && !i_flush && !i_rst;

  always_comb begin
    w_next      = r_state;
    o_mem_rd_en = 1'b0;
    o_mem_addr  = i_pc;
    case (r_state)
      REQ_OP: begin
        o_mem_rd_en = 1'b1;
        w_next      = CAP_OP;
      end
      CAP_OP: begin
        if (w_dec_size == 2'd1) begin
          w_next = VALID;
        end else begin
          o_mem_rd_en = 1'b1;
          o_mem_addr  = w_pc_p1;
          w_next      = CAP_B1;
        end
      end
      CAP_B1: begin
        if (r_size == 2'd3) begin
          o_mem_rd_en = 1'b1;
          o_mem_addr  = w_pc_p2;
          w_next      = CAP_B2;
        end else begin
          w_next = VALID;
        end
      end
      CAP_B2:  w_next = VALID;
      VALID:   if (i_instr_ready) w_next = REQ_OP;
      default: w_next = REQ_OP;
    endcase
    if (i_flush) w_next = REQ_OP;
    if (i_rst) begin
      o_mem_rd_en = 1'b0;
      o_mem_addr  = i_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_state   <= REQ_OP;
      r_opcode  <= 8'h00;
      r_op1     <= 8'h00;
      r_op2     <= 8'h00;
      r_size    <= 2'd1;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        CAP_OP: begin
          r_opcode  <= i_mem_rdata;
          r_size    <= w_dec_size;
          r_illegal <= (i_mem_rdata[7:6] == 2'b11);
          r_op1     <= 8'h00;
          r_op2     <= 8'h00;
        end
        CAP_B1:  r_op1 <= i_mem_rdata;
        CAP_B2:  r_op2 <= i_mem_rdata;
        default: ;
      endcase
    end
  end

  assign o_instr_valid   = (r_state == VALID);
  assign o_instr_opcode  = r_opcode;
  assign o_instr_op1     = r_op1;
  assign o_instr_op2     = r_op2;
  assign o_instr_size    = r_size;
  assign o_instr_illegal = r_illegal;
  assign o_pc_hold       = !w_handoff;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and random checks of instr_fetch against a byte-memory and PC model
module tb_instr_fetch;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic          flush;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          valid;
  logic          ready;
  logic [7:0]    opcode;
  logic [7:0]    op1;
  logic [7:0]    op2;
  logic [1:0]    size;
  logic          illegal;
  logic          pc_hold;

  logic [7:0]    mem [0:(1<<AW)-1];
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_flush(flush),
    .o_mem_rd_en(mem_rd_en), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
    .o_instr_valid(valid), .i_instr_ready(ready),
    .o_instr_opcode(opcode), .o_instr_op1(op1), .o_instr_op2(op2),
    .o_instr_size(size), .o_instr_illegal(illegal), .o_pc_hold(pc_hold)
  );

  // Program memory: data one cycle after the strobe, garbage otherwise so stray captures show up.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'($urandom);

  function automatic int exp_size(input logic [7:0] op);
    return (op[7:6] == 2'b01) ? 2 : (op[7:6] == 2'b10) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One instruction starting in its REQ_OP cycle; optionally aborted by flush/rst at cycle abort_at.
  task automatic fetch_one(input int stall, input int abort_at, input bit use_rst, input int next_pc);
    logic [AW-1:0] p;
    logic [7:0]    e_op, e_b1, e_b2;
    int            sz, lat;
    bit            ab, e_rd;
    p    = pc;
    e_op = mem[p];
    sz   = exp_size(e_op);
    lat  = sz + 1;
    e_b1 = (sz >= 2) ? mem[AW'(p + 1)] : 8'h00;
    e_b2 = (sz == 3) ? mem[AW'(p + 2)] : 8'h00;
    for (int n = 0; n <= lat + stall; n++) begin
      ab    = (n == abort_at);
      ready = (n < lat) ? 1'($urandom_range(0, 1)) : (n == lat + stall);
      flush = ab && !use_rst;
      rst   = ab && use_rst;
      #1;
      e_rd = !(ab && use_rst) && (n == 0 || (n == 1 && sz > 1) || (n == 2 && sz == 3));
      chk("rd_en", 32'(mem_rd_en), 32'(e_rd));
      if (e_rd) chk("addr", 32'(mem_addr), 32'(AW'(p + n)));
      chk("valid", 32'(valid), 32'(n >= lat));
      chk("pc_hold", 32'(pc_hold), 32'(!(n == lat + stall && !ab)));
      if (n >= lat) begin
        chk("opcode", 32'(opcode), 32'(e_op));
        chk("op1", 32'(op1), 32'(e_b1));
        chk("op2", 32'(op2), 32'(e_b2));
        chk("size", 32'(size), 32'(sz));
        chk("illegal", 32'(illegal), 32'(e_op[7:6] == 2'b11));
      end
      @(posedge clk);
      #1;
      if (ab) begin
        flush = 1'b0;
        rst   = 1'b0;
        #1;
        chk("abort_valid", 32'(valid), 32'(0));
        chk("abort_hold", 32'(pc_hold), 32'(1));
        chk("abort_rd_en", 32'(mem_rd_en), 32'(1));
        chk("abort_addr", 32'(mem_addr), 32'(p));
        if (use_rst) begin
          chk("rst_opcode", 32'(opcode), 32'(0));
          chk("rst_op1", 32'(op1), 32'(0));
          chk("rst_op2", 32'(op2), 32'(0));
          chk("rst_size", 32'(size), 32'(1));
          chk("rst_illegal", 32'(illegal), 32'(0));
        end
        return;
      end
    end
    pc = (next_pc < 0) ? AW'(p + AW'(sz)) : AW'(next_pc);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    rst   = 1'b1;
    flush = 1'b0;
    ready = 1'b0;
    pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(valid), 32'(0));
    chk("reset_hold", 32'(pc_hold), 32'(1));
    chk("reset_rd_en", 32'(mem_rd_en), 32'(0));
    chk("reset_opcode", 32'(opcode), 32'(0));
    chk("reset_size", 32'(size), 32'(1));
    chk("reset_illegal", 32'(illegal), 32'(0));
    rst = 1'b0;

    mem[9'h000] = 8'h05;
    mem[9'h001] = 8'h00;
    fetch_one(0, -1, 1'b0, -1);
    fetch_one(0, -1, 1'b0, 'h10);
    mem[9'h010] = 8'h80; mem[9'h011] = 8'h12; mem[9'h012] = 8'h34;
    fetch_one(0, -1, 1'b0, 'h20);
    mem[9'h020] = 8'h40; mem[9'h021] = 8'hAB;
    fetch_one(5, -1, 1'b0, 'h1FF);
    mem[9'h1FF] = 8'h41; mem[9'h000] = 8'h77;
    fetch_one(1, -1, 1'b0, -1);
    mem[9'h001] = 8'h80; mem[9'h002] = 8'h5A; mem[9'h003] = 8'hC6;
    fetch_one(0, 2, 1'b0, -1);
    fetch_one(0, -1, 1'b0, 'h30);
    mem[9'h030] = 8'h05;
    fetch_one(0, 2, 1'b0, -1);
    fetch_one(2, 4, 1'b0, 'h40);
    mem[9'h040] = 8'hC3; mem[9'h041] = 8'hC3;
    fetch_one(0, -1, 1'b0, -1);
    fetch_one(0, 1, 1'b1, -1);
    fetch_one(0, -1, 1'b0, -1);

    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 150; k++) begin
      fetch_one($urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << AW) - 1)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
